// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one multicycle combinational multiplier
// among NREQ requesters, with a registered valid/ready product response.

module multiplier #(
    parameter int width = 64
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] y
);
    // Ripple partial-product chain; long path, so the caller holds operands for several cycles.
    always_comb begin
        y = '0;
        for (int i = 0; i < width; i++)
            y = y + (b[i] ? (a << i) : '0);
    end
endmodule

module mult_share_ctrl #(
    parameter int WIDTH      = 64,
    parameter int NREQ       = 4,
    parameter int MUL_CYCLES = 4,
    parameter int ID_W       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready,
    output logic                  busy
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t              state, state_nx;
    logic [WIDTH-1:0]    op_a, op_b, sel_a, sel_b, y;
    logic [ID_W-1:0]     op_id, last_grant, gidx;
    logic [CNT_W-1:0]    cnt;
    logic [2*NREQ-1:0]   rot;
    logic                take;
    int                  s;

    multiplier #(.width(WIDTH)) u_mul (.a(op_a), .b(op_b), .y(y));

    assign take = rst_n && state == IDLE && |req_valid;
    assign busy = state != IDLE;

    // Rotate so bit 0 is the slot after last_grant; lowest set bit wins.
    always_comb begin
        rot = {req_valid, req_valid} >> (int'(last_grant) + 1);
        s   = 0;
        for (int p = NREQ - 1; p >= 0; p--)
            if (rot[p]) s = int'(last_grant) + 1 + p;
        gidx = ID_W'(s >= NREQ ? s - NREQ : s);
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            if (gidx == ID_W'(i)) begin
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
                req_ready[i] = take;
            end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = take ? MUL : IDLE;
            MUL:     state_nx = (cnt == '0) ? DONE : MUL;
            DONE:    state_nx = rsp_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            if (take) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                op_id      <= gidx;
                last_grant <= gidx;
                cnt        <= CNT_W'(MUL_CYCLES - 1);
            end
            if (state == MUL) begin
                if (cnt != '0) cnt <= cnt - CNT_W'(1);
                else begin
                    rsp_data  <= y;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
            end
            if (state == DONE && rsp_ready) rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed and randomised checks of mult_share_ctrl against a
// transaction-timeline reference model (accept time, product, round-robin order).

module tb_mult_share_ctrl;
    localparam int WIDTH = 64, NREQ = 4, MUL_CYCLES = 4, ID_W = 2;

    logic                  clk = 1'b0, rst_n = 1'b1, rsp_ready = 1'b0;
    logic [NREQ-1:0]       req_valid = '0, req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0]      a_arr [NREQ];
    logic [WIDTH-1:0]      b_arr [NREQ];
    logic                  rsp_valid, busy;
    logic [WIDTH-1:0]      rsp_data;
    logic [ID_W-1:0]       rsp_id;

    int total = 0, bad = 0, cyc = 0, acc_cyc = 0, last_g = NREQ - 1, hs_cyc = -1;
    int exp_id = 0, shown_id = 0;
    bit inflight = 1'b0;
    logic [63:0] exp_data = '0, shown_data = '0;
    int grants[$];
    int acc_q[$];
    int waited[NREQ];

    mult_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_arr[i];
            req_b[i*WIDTH +: WIDTH] = b_arr[i];
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // First requester with valid set, scanning forward from the previous winner.
    function automatic int pick(input logic [NREQ-1:0] v);
        int r = -1;
        for (int k = 1; k <= NREQ; k++)
            for (int i = 0; i < NREQ; i++)
                if (r < 0 && i == (last_g + k) % NREQ && v[i]) r = i;
        return r;
    endfunction

    // One clock: check outputs against the model, then advance the model over the edge.
    task automatic tick();
        logic [NREQ-1:0] exp_rr;
        logic [63:0] prod;
        int g;
        bit exp_v, accept, release_;
        #1;
        exp_v = inflight && (cyc >= acc_cyc + MUL_CYCLES);
        g = pick(req_valid);
        exp_rr = (!inflight && g >= 0) ? (NREQ'(1) << g) : '0;
        if (exp_v) begin
            shown_data = exp_data;
            shown_id   = exp_id;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        chk("busy", 64'(busy), 64'(inflight));
        chk("rsp_data", rsp_data, shown_data);
        chk("rsp_id", 64'(rsp_id), 64'(shown_id));
        prod = '0;
        for (int i = 0; i < NREQ; i++)
            if (i == g) prod = a_arr[i] * b_arr[i];
        accept   = !inflight && g >= 0;
        release_ = exp_v && rsp_ready;
        @(posedge clk);
        cyc++;
        if (release_) begin
            inflight = 1'b0;
            hs_cyc   = cyc;
        end
        if (accept) begin
            inflight = 1'b1;
            acc_cyc  = cyc;
            exp_data = prod;
            exp_id   = g;
            last_g   = g;
            grants.push_back(g);
            acc_q.push_back(cyc);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_data", rsp_data, 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        inflight = 1'b0;
        last_g = NREQ - 1;
        shown_data = '0;
        shown_id = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (inflight && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(inflight), 64'(0));
    endtask

    task automatic run_one(input int id, input logic [63:0] a, input logic [63:0] b, input logic [63:0] want);
        int n = 0, n0 = grants.size();
        a_arr[id] = a;
        b_arr[id] = b;
        req_valid = NREQ'(1) << id;
        rsp_ready = 1'b1;
        while (grants.size() == n0 && n < 20) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("grant_id", 64'(grants.size() > n0 ? grants[$] : -1), 64'(id));
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("latency", 64'(n), 64'(MUL_CYCLES));
        chk("result", rsp_data, want);
        chk("result_id", 64'(rsp_id), 64'(id));
        tick();
        chk("busy_after_hs", 64'(busy), 64'(0));
    endtask

    task automatic rr_run(input logic [NREQ-1:0] mask, input int cnt, input int exp_seq[6]);
        int n = 0;
        grants.delete();
        acc_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = {$urandom, $urandom};
            b_arr[i] = {$urandom, $urandom};
        end
        req_valid = mask;
        rsp_ready = 1'b1;
        while (grants.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        drain();
        chk("rr_count", 64'(grants.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < grants.size(); i++)
            chk("rr_order", 64'(grants[i]), 64'(exp_seq[i]));
        for (int i = 1; i < cnt && i < acc_q.size(); i++)
            chk("rr_spacing", 64'(acc_q[i] - acc_q[i-1]), 64'(MUL_CYCLES + 2));
    endtask

    initial begin
        int n, sz, g, n0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            waited[i] = 0;
        end
        #2;
        do_reset();

        // single request and truncation corner cases
        run_one(0, 64'd3, 64'd5, 64'd15);
        run_one(0, 64'h8000_0000_0000_0000, 64'd2, 64'd0);
        run_one(2, '1, '1, 64'd1);
        run_one(3, 64'd0, '1, 64'd0);
        chk("hold_after_hs_data", rsp_data, 64'd0);
        chk("hold_after_hs_id", 64'(rsp_id), 64'(3));

        // round robin on all four, then on 1 and 3 from reset priority
        do_reset();
        rr_run(4'b1111, 6, '{0, 1, 2, 3, 0, 1});
        do_reset();
        rr_run(4'b1010, 4, '{1, 3, 1, 3, 0, 0});

        // backpressure with competing requests
        a_arr[0] = 64'd7;
        b_arr[0] = 64'd9;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        n0 = grants.size();
        n = 0;
        while (grants.size() == n0 && n < 20) begin
            tick();
            n++;
        end
        req_valid = 4'b1110;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data", rsp_data, 64'd63);
            chk("bp_id", 64'(rsp_id), 64'(0));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        n0 = grants.size();
        tick();
        tick();
        chk("bp_regrant_gap", 64'(grants.size() > n0 ? acc_q[$] - hs_cyc : -1), 64'(1));
        chk("bp_regrant_id", 64'(grants.size() > n0 ? grants[$] : -1), 64'(1));
        drain();

        // reset during the second MUL cycle
        a_arr[1] = 64'd11;
        b_arr[1] = 64'd13;
        req_valid = 4'b0010;
        n0 = grants.size();
        n = 0;
        while (grants.size() == n0 && n < 20) begin
            tick();
            n++;
        end
        req_valid = '0;
        tick();
        do_reset();
        grants.delete();
        req_valid = 4'b0101;
        n = 0;
        while (grants.size() < 2 && n < 60) begin
            sz = grants.size();
            tick();
            n++;
            if (grants.size() > sz) req_valid &= ~(NREQ'(1) << grants[$]);
        end
        drain();
        chk("mid_rst_count", 64'(grants.size()), 64'(2));
        if (grants.size() >= 2) begin
            chk("mid_rst_first", 64'(grants[0]), 64'(0));
            chk("mid_rst_second", 64'(grants[1]), 64'(2));
        end

        // randomised traffic with random backpressure
        n0 = grants.size();
        n = 0;
        while (grants.size() - n0 < 1000 && n < 60000) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    a_arr[i] = {$urandom, $urandom};
                    b_arr[i] = {$urandom, $urandom};
                    req_valid[i] = 1'b1;
                end
            rsp_ready = 1'($urandom_range(0, 1));
            sz = grants.size();
            tick();
            n++;
            if (grants.size() > sz) begin
                g = grants[$];
                for (int i = 0; i < NREQ; i++)
                    if (i == g) waited[i] = 0;
                    else if (req_valid[i]) begin
                        waited[i]++;
                        chk("starve", 64'(waited[i] <= NREQ - 1), 64'(1));
                    end
                req_valid &= ~(NREQ'(1) << g);
            end
        end
        chk("rand_count", 64'(grants.size() - n0 >= 1000), 64'(1));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
